// File: rtl/pc_next_unit.sv
`timescale 1ns/1ps
// pc_next_unit: program-counter unit for the single-cycle RV32I core.
// It resolves branch and jump outcomes from the ALU compare flags and
// decoded control, then registers the next PC. A taken target with
// bit[1] set redirects to a trap vector for one cycle.
// Optional feature: define BRANCH_COUNTERS_EN to add the branch
// statistics counters br_count and br_taken_count.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic        cmp_eq,
  input  logic        cmp_lt,
  input  logic        cmp_ltu,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        branch_taken,
  output logic        misalign_trap,
`ifdef BRANCH_COUNTERS_EN
  output logic [31:0] trap_epc,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
`else
  output logic [31:0] trap_epc
`endif
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state;
  logic        in_run;
  logic        cond_met;
  logic        misaligned;
  logic [31:0] jalr_sum;
  logic [31:0] target;

  assign pc_plus4 = pc + 32'd4;
  assign in_run   = (state == RUN);

  // Select the branch condition from the ALU flags using funct3.
  always_comb begin
    cond_met = 1'b0;
    case (funct3)
      3'b000:  cond_met = cmp_eq;
      3'b001:  cond_met = ~cmp_eq;
      3'b100:  cond_met = cmp_lt;
      3'b101:  cond_met = ~cmp_lt;
      3'b110:  cond_met = cmp_ltu;
      3'b111:  cond_met = ~cmp_ltu;
      default: cond_met = 1'b0;
    endcase
  end

  // Compute the redirect target; JALR wins over JAL and branches share pc+imm.
  always_comb begin
    jalr_sum = rs1_val + imm;
    if (is_jalr) begin
      target = jalr_sum & ~32'h1;
    end else begin
      target = pc + imm;
    end
  end

  assign branch_taken = in_run & (is_jal | is_jalr | (is_branch & cond_met));
  assign misaligned   = branch_taken & target[1];

  // Sequence the PC, FSM state, trap pulse and faulting-PC capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HOLD;
      pc            <= RESET_VECTOR;
      pc_valid      <= 1'b0;
      misalign_trap <= 1'b0;
      trap_epc      <= 32'h0;
    end else if (!stall) begin
      case (state)
        HOLD: begin
          state         <= RUN;
          pc            <= pc_plus4;
          pc_valid      <= 1'b1;
          misalign_trap <= 1'b0;
        end
        RUN: begin
          pc_valid <= 1'b1;
          if (misaligned) begin
            state         <= TRAP;
            pc            <= TRAP_VECTOR;
            trap_epc      <= pc;
            misalign_trap <= 1'b1;
          end else begin
            state         <= RUN;
            misalign_trap <= 1'b0;
            if (branch_taken) begin
              pc <= target;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        TRAP: begin
          state         <= RUN;
          pc            <= pc_plus4;
          pc_valid      <= 1'b1;
          misalign_trap <= 1'b0;
        end
        default: begin
          state         <= HOLD;
          pc            <= RESET_VECTOR;
          pc_valid      <= 1'b0;
          misalign_trap <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_COUNTERS_EN
  // Count executed branches and those whose condition held, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count       <= 32'h0;
      br_taken_count <= 32'h0;
    end else if (!stall && in_run && is_branch) begin
      br_count <= br_count + 32'd1;
      if (cond_met) begin
        br_taken_count <= br_taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
`timescale 1ns/1ps
// tb_pc_next_unit: self-checking bench for pc_next_unit with directed
// vectors, multi-cycle trap/stall/reset sequences and random stimulus
// compared against a behavioural reference model.
module tb_pc_next_unit;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        cmp_eq, cmp_lt, cmp_ltu;
  logic [31:0] imm, rs1_val;
  logic [31:0] pc, pc_plus4, trap_epc;
  logic        pc_valid, branch_taken, misalign_trap;
`ifdef BRANCH_COUNTERS_EN
  logic [31:0] br_count, br_taken_count;
`endif

  always #5 clk = ~clk;

  pc_next_unit #(
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .is_branch     (is_branch),
    .is_jal        (is_jal),
    .is_jalr       (is_jalr),
    .funct3        (funct3),
    .cmp_eq        (cmp_eq),
    .cmp_lt        (cmp_lt),
    .cmp_ltu       (cmp_ltu),
    .imm           (imm),
    .rs1_val       (rs1_val),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .branch_taken  (branch_taken),
    .misalign_trap (misalign_trap),
`ifdef BRANCH_COUNTERS_EN
    .trap_epc      (trap_epc),
    .br_count      (br_count),
    .br_taken_count(br_taken_count)
`else
    .trap_epc      (trap_epc)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [31:0] rs1_val;
  } stim_t;

  typedef struct {
    logic [31:0] start_pc;
    stim_t       s;
    logic        exp_taken;
    logic [31:0] exp_next;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state, tracked in terms of what the PC unit promises.
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_epc, m_bc, m_btc;
  logic        m_valid, m_trap, m_hold;
  logic        last_taken;

  logic [31:0] ops [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
  vec_t        tbl [13];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic cond_holds(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t mk(input logic br, input logic jal, input logic jalr,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] im,
                               input logic [31:0] rs1);
    stim_t s;
    s = idle();
    s.is_branch = br;
    s.is_jal    = jal;
    s.is_jalr   = jalr;
    s.funct3    = f3;
    s.op_a      = a;
    s.op_b      = b;
    s.imm       = im;
    s.rs1_val   = rs1;
    return s;
  endfunction

  function automatic stim_t jump(input logic [31:0] addr);
    return mk(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, addr);
  endfunction

  task automatic applyStimulus(input stim_t s);
    logic        run, cond, taken;
    logic [31:0] tgt;
    rst       = s.rst;
    stall     = s.stall;
    is_branch = s.is_branch;
    is_jal    = s.is_jal;
    is_jalr   = s.is_jalr;
    funct3    = s.funct3;
    imm       = s.imm;
    rs1_val   = s.rs1_val;
    cmp_eq    = (s.op_a == s.op_b);
    cmp_lt    = ($signed(s.op_a) < $signed(s.op_b));
    cmp_ltu   = (s.op_a < s.op_b);
    #1;
    run   = m_known && !m_hold && !m_trap;
    cond  = cond_holds(s.funct3, s.op_a, s.op_b);
    taken = run && (s.is_jal || s.is_jalr || (s.is_branch && cond));
    tgt   = s.is_jalr ? ((s.rs1_val + s.imm) & 32'hFFFF_FFFE) : (m_pc + s.imm);
    last_taken = branch_taken;
    if (m_known) begin
      checkOutput("branch_taken", {31'h0, branch_taken}, {31'h0, taken});
      checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
    end
    @(posedge clk);
    if (s.rst) begin
      m_known = 1'b1;
      m_pc    = RESET_VECTOR;
      m_valid = 1'b0;
      m_trap  = 1'b0;
      m_hold  = 1'b1;
      m_epc   = 32'h0;
      m_bc    = 32'h0;
      m_btc   = 32'h0;
    end else if (m_known && !s.stall) begin
      if (run && s.is_branch) begin
        m_bc = m_bc + 32'd1;
        if (cond) m_btc = m_btc + 32'd1;
      end
      if (taken && tgt[1]) begin
        m_epc  = m_pc;
        m_pc   = TRAP_VECTOR;
        m_trap = 1'b1;
      end else begin
        m_pc   = taken ? tgt : m_pc + 32'd4;
        m_trap = 1'b0;
      end
      m_hold  = 1'b0;
      m_valid = 1'b1;
    end
    #1;
    if (m_known) begin
      checkOutput("pc", pc, m_pc);
      checkOutput("pc_valid", {31'h0, pc_valid}, {31'h0, m_valid});
      checkOutput("misalign_trap", {31'h0, misalign_trap}, {31'h0, m_trap});
      checkOutput("trap_epc", trap_epc, m_epc);
`ifdef BRANCH_COUNTERS_EN
      checkOutput("br_count", br_count, m_bc);
      checkOutput("br_taken_count", br_taken_count, m_btc);
`endif
    end
  endtask

  task automatic doReset();
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
  endtask

  // Bound the whole run so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence: directed vectors, corner sequences, then random.
  initial begin
    stim_t s;

    tbl[0]  = '{32'h10, mk(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h0), 1'b1, 32'h30};
    tbl[1]  = '{32'h10, mk(1, 0, 0, 3'b000, 32'd5, 32'd6, 32'h20, 32'h0), 1'b0, 32'h14};
    tbl[2]  = '{32'h10, mk(1, 0, 0, 3'b001, 32'd5, 32'd6, 32'h20, 32'h0), 1'b1, 32'h30};
    tbl[3]  = '{32'h10, mk(1, 0, 0, 3'b110, 32'd1, 32'h8000_0000, 32'h40, 32'h0), 1'b1, 32'h50};
    tbl[4]  = '{32'h10, mk(1, 0, 0, 3'b100, 32'd1, 32'h8000_0000, 32'h40, 32'h0), 1'b0, 32'h14};
    tbl[5]  = '{32'h10, mk(1, 0, 0, 3'b011, 32'd5, 32'd6, 32'h40, 32'h0), 1'b0, 32'h14};
    tbl[6]  = '{32'h10, mk(1, 0, 0, 3'b101, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h0), 1'b1, 32'h0};
    tbl[7]  = '{32'h10, mk(1, 0, 0, 3'b111, 32'd1, 32'h8000_0000, 32'h40, 32'h0), 1'b0, 32'h14};
    tbl[8]  = '{32'h20, mk(0, 0, 1, 3'b000, 32'd0, 32'd0, 32'h0, 32'h1001), 1'b1, 32'h1000};
    tbl[9]  = '{32'h20, mk(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h100, 32'h0), 1'b1, 32'h120};
    tbl[10] = '{32'h20, mk(1, 1, 1, 3'b000, 32'd5, 32'd5, 32'h8, 32'h200), 1'b1, 32'h208};
    tbl[11] = '{32'h20, mk(1, 1, 0, 3'b000, 32'd5, 32'd6, 32'h8, 32'h0), 1'b1, 32'h28};
    tbl[12] = '{32'h10, mk(1, 0, 0, 3'b010, 32'd5, 32'd5, 32'h40, 32'h0), 1'b0, 32'h14};

    // Reset and release
    doReset();
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_pc_valid", {31'h0, pc_valid}, 32'h0);
    checkOutput("reset_trap", {31'h0, misalign_trap}, 32'h0);
    applyStimulus(idle());
    checkOutput("release_pc", pc, 32'h4);
    checkOutput("release_pc_valid", {31'h0, pc_valid}, 32'h1);

    // Stall while in HOLD keeps pc_valid low
    doReset();
    s = idle();
    s.stall = 1'b1;
    applyStimulus(s);
    checkOutput("hold_stall_pc", pc, 32'h0);
    checkOutput("hold_stall_valid", {31'h0, pc_valid}, 32'h0);
    applyStimulus(idle());
    checkOutput("hold_exit_pc", pc, 32'h4);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(jump(tbl[i].start_pc));
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("vec%0d_taken", i), {31'h0, last_taken}, {31'h0, tbl[i].exp_taken});
      checkOutput($sformatf("vec%0d_next_pc", i), pc, tbl[i].exp_next);
    end

    // Sequential wrap at the top of the address space
    applyStimulus(jump(32'hFFFF_FFFC));
    applyStimulus(idle());
    checkOutput("wrap_pc", pc, 32'h0);

    // Misaligned JAL trap, one-cycle pulse, controls ignored in TRAP
    applyStimulus(jump(32'h40));
    applyStimulus(mk(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h6, 32'h0));
    checkOutput("trap_pc", pc, 32'h100);
    checkOutput("trap_pulse", {31'h0, misalign_trap}, 32'h1);
    checkOutput("trap_epc_val", trap_epc, 32'h40);
    applyStimulus(mk(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h20, 32'h0));
    checkOutput("trap_ignores_ctrl", {31'h0, last_taken}, 32'h0);
    checkOutput("after_trap_pc", pc, 32'h104);
    checkOutput("after_trap_pulse", {31'h0, misalign_trap}, 32'h0);

    // Misaligned trap held by a 3-cycle stall
    applyStimulus(jump(32'h40));
    applyStimulus(mk(0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h6, 32'h0));
    for (int i = 0; i < 3; i++) begin
      s = idle();
      s.stall = 1'b1;
      applyStimulus(s);
      checkOutput($sformatf("trap_stall%0d_pulse", i), {31'h0, misalign_trap}, 32'h1);
      checkOutput($sformatf("trap_stall%0d_pc", i), pc, 32'h100);
    end
    applyStimulus(idle());
    checkOutput("trap_stall_release_pc", pc, 32'h104);
    checkOutput("trap_stall_release_pulse", {31'h0, misalign_trap}, 32'h0);

    // Misaligned JALR target (bit 0 cleared, bit 1 set)
    applyStimulus(jump(32'h80));
    applyStimulus(mk(0, 0, 1, 3'd0, 32'd0, 32'd0, 32'h0, 32'h1003));
    checkOutput("jalr_trap_pc", pc, 32'h100);
    checkOutput("jalr_trap_epc", trap_epc, 32'h80);
    applyStimulus(idle());

    // Stall beats a taken branch, reset beats stall
    applyStimulus(jump(32'h200));
    s = mk(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h0);
    s.stall = 1'b1;
    applyStimulus(s);
    checkOutput("stall_branch_pc", pc, 32'h200);
    s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("rst_in_stall_pc", pc, 32'h0);
    checkOutput("rst_in_stall_valid", {31'h0, pc_valid}, 32'h0);
    applyStimulus(idle());

`ifdef BRANCH_COUNTERS_EN
    // Five branches, three taken, one stalled branch ignored
    doReset();
    applyStimulus(idle());
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mk(1, 0, 0, (i < 3) ? 3'b000 : 3'b001, 32'd7, 32'd7, 32'h8, 32'h0));
      if (i == 1) begin
        s = mk(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h8, 32'h0);
        s.stall = 1'b1;
        applyStimulus(s);
      end
    end
    checkOutput("counter_br_count", br_count, 32'd5);
    checkOutput("counter_br_taken", br_taken_count, 32'd3);
`endif

    // Random stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      int sel;
      s = idle();
      sel         = $urandom_range(0, 3);
      s.is_branch = (sel == 1);
      s.is_jal    = (sel == 2);
      s.is_jalr   = (sel == 3);
      s.funct3    = 3'($urandom_range(0, 7));
      s.op_a      = ops[$urandom_range(0, 3)];
      s.op_b      = ops[$urandom_range(0, 3)];
      s.imm       = 32'(int'($urandom_range(0, 63)) * 2 - 64);
      s.rs1_val   = 32'($urandom_range(0, 4095));
      s.stall     = ($urandom_range(0, 9) == 0);
      s.rst       = ($urandom_range(0, 49) == 0);
      applyStimulus(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Sequential program-counter unit for the single-cycle RV32I core.
- Consumes the ALU's branch comparison flags together with decoded control, resolves branch/jump outcome, and registers the next PC.
- Sits between the ALU/decoder and instruction memory.
- Also detects misaligned control-transfer targets and redirects to a trap vector.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and FSM state; higher priority than all events except rst.
- is_branch  input  1  current instruction is a B-type.
- is_jal  input  1  current instruction is JAL.
- is_jalr  input  1  current instruction is JALR.
- funct3  input  3  branch condition select.
- cmp_eq  input  1  ALU flag: rs1 == rs2.
- cmp_lt  input  1  ALU flag: rs1 < rs2, signed.
- cmp_ltu  input  1  ALU flag: rs1 < rs2, unsigned (inverse of subtract carry-out).
- imm  input  32  sign-extended B/J/I immediate.
- rs1_val  input  32  JALR base.
- pc  output  32  registered current PC.
- pc_plus4  output  32  pc + 4, combinational, wraps mod 2^32.
- pc_valid  output  1  low in the first cycle after reset; high otherwise.
- branch_taken  output  1  combinational; current instruction redirects the PC.
- misalign_trap  output  1  registered one-cycle pulse when a trap is taken.
- trap_epc  output  32  PC of the faulting instruction, captured at trap.

Behaviour:
- FSM states:
  - HOLD: entered on rst. pc_valid=0, PC held at RESET_VECTOR. Next cycle goes to RUN, unless stall or rst is asserted.
  - RUN: normal operation.
  - TRAP: one cycle. misalign_trap=1, pc=TRAP_VECTOR, pc_valid=1, control inputs ignored. Next state is RUN, unless stall.
- Reset values: pc=RESET_VECTOR, pc_valid=0, misalign_trap=0, trap_epc=0, state=HOLD. Reset mid-operation (any state, including during stall) takes effect at the next edge.
- Branch condition by funct3:
  - 000 BEQ: cmp_eq
  - 001 BNE: ~cmp_eq
  - 100 BLT: cmp_lt
  - 101 BGE: ~cmp_lt
  - 110 BLTU: cmp_ltu
  - 111 BGEU: ~cmp_ltu
  - 010/011: not taken.
- Target computation (all adds 32-bit, wrap-around, no overflow detection):
  - Branch and JAL: pc + imm.
  - JALR: (rs1_val + imm) & ~32'h1.
- branch_taken = RUN & (is_jal | is_jalr | (is_branch & condition)).
- If more than one of is_branch/is_jal/is_jalr is set, priority is jalr > jal > branch.
- Misalignment: a taken target with bit[1]=1 in RUN causes the next state TRAP, pc<=TRAP_VECTOR, and trap_epc<=current pc. Bit[0] is never checked for JALR because it is cleared.
- Per-edge priority: rst > stall > misaligned trap > taken target > pc_plus4.
- stall holds pc, state, and trap_epc. If stall is asserted while in TRAP, misalign_trap stays high until the stall releases; the pulse is exactly one unstalled cycle.
- Single-cycle latency: the resolved target appears on pc the edge after the instruction is presented.

Optional Feature:
- Macro: BRANCH_COUNTERS_EN.
- When defined: adds outputs br_count[31:0] and br_taken_count[31:0].
  - br_count increments on every unstalled RUN cycle with is_branch=1.
  - br_taken_count increments when that branch is also taken (including a misaligned taken branch).
  - Both reset to 0 and wrap at 2^32.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then release → pc=0, pc_valid=0 for one cycle; the next edge gives pc=4 with pc_valid=1.
- BEQ taken: pc=0x10, is_branch=1, funct3=000, cmp_eq=1, imm=0x20 → branch_taken=1, next pc=0x30. Repeat with cmp_eq=0 → next pc=0x14.
- Unsigned vs signed: funct3=110, cmp_ltu=1, cmp_lt=0 → taken. funct3=100 with the same flags → not taken. funct3=011 → not taken, pc+4.
- JALR LSB clear and wrap: rs1_val=0x1001, imm=0 → pc=0x1000. pc=0xFFFF_FFFC sequential → pc=0x0000_0000.
- Misaligned trap: pc=0x40, is_jal=1, imm=0x6 → next pc=0x100, misalign_trap=1 for 1 cycle, trap_epc=0x40, then pc=0x104. Repeat with stall asserted for 3 cycles in TRAP → pulse held 4 cycles, pc stays 0x100.
- Stall/reset priority and counters: stall=1 with a taken branch → pc unchanged. rst during stall → pc=0 next edge. With BRANCH_COUNTERS_EN, 5 branches, 3 taken → br_count=5, br_taken_count=3.
